// File: rtl/wta_pkg.sv
// Shared WTA bus constants: selector codes, bus widths and the dump sequencer state type.
package wta_pkg;

  localparam int WTA_DATA_W = 16;
  localparam int WTA_SEL_W  = 8;

  localparam logic [WTA_SEL_W-1:0] WTA_SEL_N      = 8'd1;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_M      = 8'd2;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_P      = 8'd3;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_R1     = 8'd4;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_ROW    = 8'd5;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_COL    = 8'd6;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_CURR   = 8'd7;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_SUM    = 8'd8;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_STA    = 8'd9;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_STB    = 8'd10;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_STC    = 8'd11;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_A      = 8'd12;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_B      = 8'd13;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_R      = 8'd14;
  localparam logic [WTA_SEL_W-1:0] WTA_SEL_COREID = 8'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } wta_state_e;

endpackage

// File: rtl/wta_dump_fifo.sv
// Small synchronous capture FIFO with registered full/empty flags and a synchronous flush.
// Head word is read straight from the storage registers, so it is stable for a whole cycle.
module wta_dump_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nx;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_nx = count;
    if (do_push && !do_pop) begin
      count_nx = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nx = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nx;
      full  <= (count_nx == FULL_CNT);
      empty <= (count_nx == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wta_dump_seq.sv
// WTA register-dump sequencer: walks the WTA mux selector, captures each word with its code
// into a FIFO and streams the snapshot out over valid/ready, pulsing done when drained.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; WTA_en low, selector parked at 0
// ST_SCAN  | WTA_en high, one capture per cycle while the FIFO has room
// ST_DRAIN | all words captured, waiting for the consumer to empty FIFO
module wta_dump_seq
  import wta_pkg::*;
#(
  parameter int DATA_W     = WTA_DATA_W,
  parameter int SEL_W      = WTA_SEL_W,
  parameter int FIRST_SEL  = 1,
  parameter int LAST_SEL   = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  WTA_sel,
  output logic              WTA_en,
  input  logic [DATA_W-1:0] wta_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [SEL_W-1:0]  dump_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] FIRST_C = SEL_W'(FIRST_SEL);
  localparam logic [SEL_W-1:0] LAST_C  = SEL_W'(LAST_SEL);

  wta_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               push;
  logic               flush;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [SEL_W+DATA_W-1:0] fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    done_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      en_d    = 1'b0;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The done cycle sits in IDLE but must not accept a new start.
          if (start && !done_q) begin
            sel_d   = FIRST_C;
            en_d    = 1'b1;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!fifo_full) begin
            push = 1'b1;
            if (sel_q == LAST_C) begin
              sel_d   = '0;
              en_d    = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = '0;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  assign pop = dump_valid & dump_ready;

  wta_dump_fifo #(
    .WIDTH (SEL_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({sel_q, wta_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign WTA_sel    = sel_q;
  assign WTA_en     = en_q;
  assign dump_valid = ~fifo_empty;
  assign dump_idx   = fifo_head[SEL_W+DATA_W-1:DATA_W];
  assign dump_data  = fifo_head[DATA_W-1:0];
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done       = done_q;

endmodule
